// File: rtl/wshb_pkg.sv
// Shared Wishbone B4 types and burst address helper for wshb_ram_slave.
// Types for cycle type, burst type and responder state, plus the next-word rule.
package wshb_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    INCR    = 3'b010,
    EOB     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } bte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SINGLE = 2'b01,
    BURST  = 2'b10
  } state_t;

  // Word address of the following beat. Wraps only touch the low bits;
  // linear carries into the upper bits so a range check can see the overflow.
  function automatic logic [31:0] next_widx(input logic [31:0] widx, input bte_t bte);
    logic [31:0] n;
    n = widx;
    case (bte)
      WRAP4:   n[1:0] = widx[1:0] + 2'd1;
      WRAP8:   n[2:0] = widx[2:0] + 3'd1;
      WRAP16:  n[3:0] = widx[3:0] + 4'd1;
      default: n = widx + 32'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wshb_ram_bytes.sv
// Byte-lane RAM for wshb_ram_slave: 4 lane write enables and a registered read,
// written in the shape block-RAM inference expects (no reset on array or read data).
module wshb_ram_bytes #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   q
);

  logic [31:0] mem [DEPTH];

  // Read-during-write to the same word returns the old contents.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 registered-feedback RAM responder with classic and incrementing bursts.
// Build option: define WSHB_RAM_ADR_CHECK_EN to terminate out-of-range beats with err.
module wshb_ram_slave
  import wshb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int ADR_W = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [ADR_W-1:0] adr,
  input  logic [31:0]      dat_ms,
  output logic [31:0]      dat_sm,
  input  logic [3:0]       sel,
  input  logic             we,
  input  logic             stb,
  input  logic             cyc,
  input  logic [2:0]       cti,
  input  logic [1:0]       bte,
  output logic             ack,
  output logic             err,
  output logic             rty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int WA_W = ADR_W - 2;

  state_t          state;
  logic            req;
  logic [WA_W-1:0] wadr;
  logic [WA_W-1:0] nxt_wadr;
  logic [31:0]     nxt_full;
  logic [AW-1:0]   widx;
  logic [AW-1:0]   rd_idx;
  logic            cur_ok;
  logic            nxt_ok;
  logic            wr_en;
  logic            rd_en;
  logic [31:0]     ram_q;
  logic            byp_en;
  logic [3:0]      byp_sel;
  logic [31:0]     byp_dat;
  logic            unused_bits;

  assign req      = cyc & stb;
  assign wadr     = adr[ADR_W-1:2];
  assign widx     = adr[AW+1:2];
  assign nxt_full = next_widx(32'(wadr), bte_t'(bte));
  assign nxt_wadr = nxt_full[WA_W-1:0];
  assign rty      = 1'b0;

`ifdef WSHB_RAM_ADR_CHECK_EN
  assign cur_ok = (wadr >> AW) == '0;
  assign nxt_ok = (nxt_wadr >> AW) == '0;
`else
  assign cur_ok = 1'b1;
  assign nxt_ok = 1'b1;
`endif

  assign unused_bits = ^{adr[1:0], nxt_full, nxt_wadr};

  // A beat completes on an edge where the master still requests and we are acking.
  assign wr_en  = (state != IDLE) & req & ack & we & cur_ok;
  assign rd_en  = req & ((state == IDLE) | ((state == BURST) & (cti_t'(cti) != EOB)));
  assign rd_idx = (state == IDLE) ? widx : nxt_wadr[AW-1:0];

  wshb_ram_bytes #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .sys_clk (sys_clk),
    .we      ({4{wr_en}} & sel),
    .waddr   (widx),
    .wdata   (dat_ms),
    .re      (rd_en),
    .raddr   (rd_idx),
    .q       (ram_q)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      ack     <= 1'b0;
      err     <= 1'b0;
      byp_en  <= 1'b0;
      byp_sel <= '0;
      byp_dat <= '0;
    end else begin
      byp_en  <= wr_en & rd_en & (rd_idx == widx);
      byp_sel <= sel;
      byp_dat <= dat_ms;
      case (state)
        IDLE: begin
          if (req) begin
            ack   <= cur_ok;
            err   <= ~cur_ok;
            state <= (cti_t'(cti) == INCR) ? BURST : SINGLE;
          end
        end
        SINGLE: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        BURST: begin
          if (req && (cti_t'(cti) != EOB)) begin
            ack <= nxt_ok;
            err <= ~nxt_ok;
          end else begin
            ack   <= 1'b0;
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Data is only driven during an ack; a write captured on the read edge overrides its lanes.
  always_comb begin
    dat_sm = '0;
    if (ack) begin
      for (int i = 0; i < 4; i++) begin
        dat_sm[8*i +: 8] = (byp_en && byp_sel[i]) ? byp_dat[8*i +: 8] : ram_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Self-checking bench for wshb_ram_slave: directed cases plus random traffic against a word-array model.
// Expectations for out-of-range accesses follow WSHB_RAM_ADR_CHECK_EN when it is defined.
module tb_wshb_ram_slave;

  localparam int DEPTH = 1024;
  localparam int ADR_W = 32;
  localparam logic [ADR_W-1:0] CANARY = 32'h0000_0FF0;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b0;
  logic [ADR_W-1:0] adr;
  logic [31:0]      dat_ms;
  logic [31:0]      dat_sm;
  logic [3:0]       sel;
  logic             we;
  logic             stb;
  logic             cyc;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic             ack;
  logic             err;
  logic             rty;

  logic [31:0] model [DEPTH];
  int n_chk = 0;
  int n_err = 0;

  wshb_ram_slave #(.DEPTH(DEPTH), .ADR_W(ADR_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .adr     (adr),
    .dat_ms  (dat_ms),
    .dat_sm  (dat_sm),
    .sel     (sel),
    .we      (we),
    .stb     (stb),
    .cyc     (cyc),
    .cti     (cti),
    .bte     (bte),
    .ack     (ack),
    .err     (err),
    .rty     (rty)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int widx_of(input logic [ADR_W-1:0] a);
    return int'((a >> 2) & (DEPTH - 1));
  endfunction

  function automatic logic exp_err_of(input logic [ADR_W-1:0] a);
`ifdef WSHB_RAM_ADR_CHECK_EN
    return (a >> ($clog2(DEPTH) + 2)) != 0;
`else
    return (a != a);
`endif
  endfunction

  task automatic model_write(input logic [ADR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int wi;
    wi = widx_of(a);
    for (int i = 0; i < 4; i++) if (s[i]) model[wi][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; cti = 3'b000; bte = 2'b00; sel = 4'h0; adr = '0; dat_ms = '0;
  endtask

  task automatic wb_single(input logic [ADR_W-1:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s);
    logic e;
    e = exp_err_of(a);
    cyc = 1; stb = 1; adr = a; we = w; dat_ms = d; sel = s; cti = 3'b000; bte = 2'b00;
    tick();
    chk("single ack", 32'(ack), 32'(!e));
    chk("single err", 32'(err), 32'(e));
    if (e) chk("single err data", dat_sm, 32'h0);
    else if (!w) chk("single rdata", dat_sm, model[widx_of(a)]);
    tick();
    chk("single one-cycle", 32'(ack | err), 32'h0);
    if (w && !e) model_write(a, d, s);
    bus_idle();
  endtask

  // Burst of n (>=2) beats; stall_at>=0 drops stb for 2 cycles after that beat.
  task automatic wb_burst(input logic [ADR_W-1:0] a0, input logic [1:0] b, input int n,
                          input logic w, input int stall_at, input logic fill);
    logic [ADR_W-1:0] av[$];
    logic [31:0]      dv[$];
    logic [3:0]       sv[$];
    int wrap, w0;
    wrap = (b == 2'b00) ? 0 : (2 << b);
    w0   = int'(a0 >> 2);
    for (int k = 0; k < n; k++) begin
      if (wrap == 0) av.push_back(ADR_W'((w0 + k) * 4));
      else           av.push_back(ADR_W'(((w0 / wrap) * wrap + ((w0 % wrap) + k) % wrap) * 4));
      dv.push_back(fill ? 32'(widx_of(av[k])) : $urandom);
      sv.push_back(fill ? 4'hF : 4'($urandom));
    end
    cyc = 1; stb = 1; we = w; bte = b;
    adr = av[0]; dat_ms = dv[0]; sel = sv[0]; cti = (n == 1) ? 3'b111 : 3'b010;
    tick();
    for (int k = 0; k < n; k++) begin
      chk("burst ack", 32'(ack), 32'h1);
      chk("burst err", 32'(err), 32'h0);
      if (!w) chk("burst rdata", dat_sm, model[widx_of(av[k])]);
      tick();
      if (w) model_write(av[k], dv[k], sv[k]);
      if (k == n - 1) begin
        chk("burst end ack", 32'(ack), 32'h0);
        bus_idle();
      end else begin
        if (k == stall_at) begin
          stb = 0; adr = CANARY; dat_ms = $urandom; we = 1; sel = 4'hF;
          chk("stall ack held", 32'(ack), 32'h1);
          tick();
          chk("stall ack drop", 32'(ack), 32'h0);
          tick();
          chk("stall ack low", 32'(ack), 32'h0);
          stb = 1; we = w;
        end
        adr = av[k+1]; dat_ms = dv[k+1]; sel = sv[k+1];
        cti = (k + 1 == n - 1) ? 3'b111 : 3'b010;
        if (k == stall_at) tick();
      end
    end
  endtask

  initial begin
    logic [ADR_W-1:0] a;
    logic [31:0] d;
    int n, op;
    bus_idle();
    #1 sys_rst = 1;
    #2;
    chk("reset ack", 32'(ack), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset rty", 32'(rty), 32'h0);
    chk("reset dat", dat_sm, 32'h0);
    repeat (2) tick();
    sys_rst = 0;
    tick();

    for (int blk = 0; blk < DEPTH / 16; blk++)
      wb_burst(ADR_W'(blk * 64), 2'b00, 16, 1'b1, -1, 1'b1);

    wb_single(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    wb_single(32'h10, 1'b0, 32'h0, 4'hF);
    chk("classic readback", model[4], 32'hDEADBEEF);

    wb_single(32'h20, 1'b1, 32'hAABBCCDD, 4'hF);
    wb_single(32'h20, 1'b1, 32'h11223344, 4'b0101);
    wb_single(32'h20, 1'b0, 32'h0, 4'hF);
    chk("byte lane model", model[8], 32'hAA22CC44);

    wb_burst(32'h100, 2'b00, 8, 1'b0, -1, 1'b0);
    wb_burst(32'h08,  2'b01, 4, 1'b0, -1, 1'b0);
    wb_burst(32'h200, 2'b00, 8, 1'b0, 3, 1'b0);
    wb_burst(32'h300, 2'b00, 8, 1'b1, 3, 1'b0);
    wb_burst(32'h300, 2'b00, 8, 1'b0, -1, 1'b0);
    wb_burst(32'h44,  2'b10, 8, 1'b0, -1, 1'b0);
    wb_burst(32'h3C,  2'b11, 16, 1'b0, -1, 1'b0);

    wb_single(32'h1000, 1'b1, 32'h5A5A1234, 4'hF);
    wb_single(32'h0, 1'b0, 32'h0, 4'hF);

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      a  = ADR_W'($urandom_range(0, DEPTH - 1) * 4);
      if (op == 0) wb_single(a, 1'b1, $urandom, 4'($urandom));
      else if (op == 1) wb_single(a, 1'b0, 32'h0, 4'hF);
      else begin
        logic [1:0] b;
        b = 2'($urandom);
        n = $urandom_range(2, 12);
        if (b == 2'b00 && widx_of(a) + n > DEPTH) a = ADR_W'((DEPTH - n) * 4);
        wb_burst(a, b, n, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 2) : -1,
                 1'b0);
      end
    end

    // Reset during the third beat of a write burst: beats 0 and 1 stay written, beat 2 never lands.
    cyc = 1; stb = 1; we = 1; bte = 2'b00; sel = 4'hF; cti = 3'b010;
    adr = 32'h800; d = $urandom; dat_ms = d;
    tick();
    tick();
    model_write(32'h800, d, 4'hF);
    adr = 32'h804; d = $urandom; dat_ms = d;
    tick();
    model_write(32'h804, d, 4'hF);
    adr = 32'h808; dat_ms = ~model[widx_of(32'h808)];
    #2 sys_rst = 1;
    #1;
    chk("midburst reset ack", 32'(ack), 32'h0);
    chk("midburst reset err", 32'(err), 32'h0);
    chk("midburst reset dat", dat_sm, 32'h0);
    bus_idle();
    tick();
    sys_rst = 0;
    tick();

    for (int i = 0; i < DEPTH; i++) wb_single(ADR_W'(i * 4), 1'b0, 32'h0, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
